// File: rtl/serial_byte_shifter.sv
// Full-duplex serial word shifter driven by an external serial clock generator.
// One start pulse arms the generator, shifts tx_data out on mosi and captures miso into rx_data.
module serial_byte_shifter #(
    parameter int BIT_COUNT  = 8,
    parameter int ACTIVE_LOW = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_COUNT-1:0] tx_data,
    output logic                 gen_start,
    input  logic                 gen_out_clk,
    input  logic                 gen_busy,
    input  logic                 miso,
    output logic                 mosi,
    output logic [BIT_COUNT-1:0] rx_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int               CNT_W    = $clog2(BIT_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(BIT_COUNT);
    localparam logic             IDLE_LVL = (ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic                 clk_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [1:0]           wait_cnt;
    logic [BIT_COUNT-1:0] tx_sr;
    logic [BIT_COUNT-1:0] rx_sr;
    logic                 load, abort, finish;
    logic                 lead, trail, shift_in, shift_out;

    function automatic logic first_bit(input logic [BIT_COUNT-1:0] w);
        return (MSB_FIRST != 0) ? w[BIT_COUNT-1] : w[0];
    endfunction

    assign lead      = (clk_q == IDLE_LVL) && (gen_out_clk != IDLE_LVL);
    assign trail     = (clk_q != IDLE_LVL) && (gen_out_clk == IDLE_LVL);
    // Edges past the last bit are ignored so a generator overrun cannot corrupt the word.
    assign shift_in  = (state == S_SHIFT) && lead  && (bit_cnt < LAST);
    assign shift_out = (state == S_SHIFT) && trail && (bit_cnt < LAST);
    assign gen_start = (state == S_ARM);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        abort     = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_ARM;
                end
            end
            S_ARM:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (gen_busy) begin
                    state_nxt = S_SHIFT;
                end else if (wait_cnt == 2'd3) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (!gen_busy) begin
                    if (bit_cnt == LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        abort     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shift registers carry no reset; they are always loaded before use.
    always_ff @(posedge sys_clk) begin
        if (load) begin
            tx_sr <= tx_data;
        end else if (shift_out) begin
            tx_sr <= (MSB_FIRST != 0) ? (tx_sr << 1) : (tx_sr >> 1);
        end
        if (shift_in) begin
            rx_sr <= (MSB_FIRST != 0) ? {rx_sr[BIT_COUNT-2:0], miso}
                                      : {miso, rx_sr[BIT_COUNT-1:1]};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= S_IDLE;
            clk_q    <= IDLE_LVL;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            mosi     <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            clk_q    <= gen_out_clk;
            done     <= finish;
            error    <= abort;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 2'd1 : 2'd0;
            if (load) begin
                busy    <= 1'b1;
                bit_cnt <= '0;
                mosi    <= first_bit(tx_data);
            end
            if (shift_in) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (shift_out) begin
                mosi <= (MSB_FIRST != 0) ? tx_sr[BIT_COUNT-2] : tx_sr[1];
            end
            if (abort || finish) begin
                busy <= 1'b0;
                mosi <= 1'b0;
            end
            if (finish) begin
                rx_data <= rx_sr;
            end
        end
    end

endmodule
